// File: rtl/rr_grant_scheduler_if.sv
// -----------------------------------------------------------------------------
// rr_grant_scheduler_if
//   Bundles the request/release inputs and the grant/status outputs of the
//   round-robin grant scheduler.
//
//   Signals:
//     req      [3:0]  level requests, one bit per requester
//     done     [3:0]  release pulse per requester (only the owner's bit counts)
//     grant    [3:0]  registered one-hot grant, or all zero
//     grant_id [1:0]  index of the current owner, valid while busy
//     busy            high while a grant is held
//     ptr      [1:0]  rotating priority pointer (highest-priority index)
//     timeout         one-cycle pulse on a forced release
//
//   Modports:
//     master  requester side: drives req/done, observes the grant outputs
//     slave   scheduler side: observes req/done, drives the grant outputs
// -----------------------------------------------------------------------------
interface rr_grant_scheduler_if;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       busy;
    logic [1:0] ptr;
    logic       timeout;

    modport master (
        output req,
        output done,
        input  grant,
        input  grant_id,
        input  busy,
        input  ptr,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output grant,
        output grant_id,
        output busy,
        output ptr,
        output timeout
    );
endinterface : rr_grant_scheduler_if

// File: rtl/rr_grant_scheduler.sv
// -----------------------------------------------------------------------------
// rr_grant_scheduler
//   Round-robin grant scheduler for four requesters sharing one resource.
//   A rotating pointer selects the highest-priority requester; the winner gets
//   a registered one-hot grant that is held until the owner releases it
//   (done pulse or request drop), after which the pointer moves past the owner.
//   Every grant is followed by one IDLE cycle before the next can be issued.
//
//   Parameters:
//     HOLD_MAX   maximum GRANT cycles before a forced release (1..255);
//                only used when RR_HOLD_LIMIT_EN is defined.
//
//   Compile-time option:
//     RR_HOLD_LIMIT_EN   builds the 8-bit hold counter and timeout pulse.
//                        Undefined: grants are held indefinitely and timeout
//                        is tied low.
//
//   Ports:
//     clk     rising-edge clock
//     rst_n   asynchronous active-low reset
//     bus     rr_grant_scheduler_if.slave (req, done in; grant, grant_id,
//             busy, ptr, timeout out -- all outputs registered)
// -----------------------------------------------------------------------------
module rr_grant_scheduler #(
    parameter int unsigned HOLD_MAX = 15
) (
    input  logic                    clk,
    input  logic                    rst_n,
    rr_grant_scheduler_if.slave     bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_q,    state_d;
    logic [3:0] grant_q,    grant_d;
    logic [1:0] grant_id_q, grant_id_d;
    logic       busy_q,     busy_d;
    logic [1:0] ptr_q,      ptr_d;
    logic       timeout_q,  timeout_d;

    // Lowest set index of a 4-bit vector; callers guarantee v != 0.
    function automatic logic [1:0] lowest_idx(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // Requests at or above the pointer take priority; if none of those are
    // active the search wraps to the full request vector.
    logic [3:0] masked_req;
    logic [1:0] winner;

    always_comb begin
        masked_req = bus.req & (4'b1111 << ptr_q);
        winner     = (masked_req != 4'b0000) ? lowest_idx(masked_req)
                                             : lowest_idx(bus.req);
    end

    // Owner-driven release; done bits of other requesters never matter.
    logic normal_release;
    assign normal_release = bus.done[grant_id_q] | ~bus.req[grant_id_q];

`ifdef RR_HOLD_LIMIT_EN
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       hold_hit;
    // The counter reads 0 in the first GRANT cycle, so HOLD_MAX GRANT cycles
    // have elapsed when the incremented value reaches HOLD_MAX.
    assign hold_hit = ((hold_cnt_q + 8'd1) == 8'(HOLD_MAX));
`else
    logic hold_hit;
    assign hold_hit = 1'b0;
    // HOLD_MAX only matters with the hold limit built in.
    logic unused_hold_max;
    assign unused_hold_max = ^8'(HOLD_MAX);
`endif

    // NOTE: every signal assigned here gets a default first, so no path
    // leaves a value unassigned and no latch can be inferred.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        busy_d     = busy_q;
        ptr_d      = ptr_q;
        timeout_d  = 1'b0;
`ifdef RR_HOLD_LIMIT_EN
        hold_cnt_d = hold_cnt_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (bus.req != 4'b0000) begin
                    state_d    = GRANT;
                    grant_d    = 4'b0001 << winner;
                    grant_id_d = winner;
                    busy_d     = 1'b1;
`ifdef RR_HOLD_LIMIT_EN
                    hold_cnt_d = 8'd0;
`endif
                end
            end

            GRANT: begin
                if (normal_release || hold_hit) begin
                    state_d   = IDLE;
                    grant_d   = 4'b0000;
                    busy_d    = 1'b0;
                    ptr_d     = grant_id_q + 2'd1;  // 3 wraps to 0
                    // A coincident owner release wins over the timeout.
                    timeout_d = hold_hit & ~normal_release;
`ifdef RR_HOLD_LIMIT_EN
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
`endif
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update
    // together from values sampled before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= 4'b0000;
            grant_id_q <= 2'd0;
            busy_q     <= 1'b0;
            ptr_q      <= 2'd0;
            timeout_q  <= 1'b0;
`ifdef RR_HOLD_LIMIT_EN
            hold_cnt_q <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
            ptr_q      <= ptr_d;
            timeout_q  <= timeout_d;
`ifdef RR_HOLD_LIMIT_EN
            hold_cnt_q <= hold_cnt_d;
`endif
        end
    end

    assign bus.grant    = grant_q;
    assign bus.grant_id = grant_id_q;
    assign bus.busy     = busy_q;
    assign bus.ptr      = ptr_q;
    assign bus.timeout  = timeout_q;

endmodule : rr_grant_scheduler

// File: tb/tb_rr_grant_scheduler.sv
// -----------------------------------------------------------------------------
// tb_rr_grant_scheduler
//   Directed, self-checking bench for rr_grant_scheduler. Expected values are
//   hand-computed from the scheduler's behaviour. Built with HOLD_MAX = 4;
//   the hold-limit step follows whether RR_HOLD_LIMIT_EN is defined.
// -----------------------------------------------------------------------------
module tb_rr_grant_scheduler;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    rr_grant_scheduler_if bus ();

    rr_grant_scheduler #(
        .HOLD_MAX (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [3:0] g,
                               input logic [1:0] id, input logic b,
                               input logic [1:0] p);
        check({tag, ".grant"}, 32'(bus.grant), 32'(g));
        if (b) check({tag, ".grant_id"}, 32'(bus.grant_id), 32'(id));
        check({tag, ".busy"},  32'(bus.busy),  32'(b));
        check({tag, ".ptr"},   32'(bus.ptr),   32'(p));
    endtask

    logic [3:0] rot_grant [5];
    logic [1:0] rot_ptr   [5];

    initial begin
        n_cmp = 0;
        n_err = 0;
        rot_grant = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        rot_ptr   = '{2'd2,    2'd3,    2'd0,    2'd1,    2'd2};

        // ---- Reset state ----
        rst_n    = 1'b0;
        bus.req  = 4'b0000;
        bus.done = 4'b0000;
        #12;
        check_state("reset", 4'b0000, 2'd0, 1'b0, 2'd0);
        check("reset.grant_id", 32'(bus.grant_id), 32'd0);
        check("reset.timeout", 32'(bus.timeout), 32'd0);
        #1 rst_n = 1'b1;
        tick();
        check_state("idle_noreq", 4'b0000, 2'd0, 1'b0, 2'd0);

        // ---- req=0101, ptr=0: grant 0001, done releases, then 0100 ----
        bus.req = 4'b0101;
        tick();
        check_state("t1.grant0", 4'b0001, 2'd0, 1'b1, 2'd0);
        bus.done = 4'b0001;
        tick();
        bus.done = 4'b0000;
        check_state("t1.release0", 4'b0000, 2'd0, 1'b0, 2'd1);
        tick();
        check_state("t1.grant2", 4'b0100, 2'd2, 1'b1, 2'd1);
        bus.done = 4'b0100;
        bus.req  = 4'b0000;
        tick();
        bus.done = 4'b0000;
        check_state("t1.release2", 4'b0000, 2'd0, 1'b0, 2'd3);

        // ---- ptr=3, req=0011: masked set empty, fall back to requester 0 ----
        bus.req = 4'b0011;
        tick();
        check_state("fallback.grant", 4'b0001, 2'd0, 1'b1, 2'd3);
        bus.done = 4'b0001;
        bus.req  = 4'b0000;
        tick();
        bus.done = 4'b0000;
        check_state("fallback.release", 4'b0000, 2'd0, 1'b0, 2'd1);

        // ---- All requesting, owner pulses done: rotation with 3->0 wrap ----
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("rot%0d.grant", k), 32'(bus.grant), 32'(rot_grant[k]));
            bus.done = rot_grant[k];
            tick();
            bus.done = 4'b0000;
            check($sformatf("rot%0d.drop", k), 32'(bus.grant), 32'd0);
            check($sformatf("rot%0d.ptr", k), 32'(bus.ptr), 32'(rot_ptr[k]));
        end
        bus.req = 4'b0000;
        tick();
        check_state("rot.idle", 4'b0000, 2'd0, 1'b0, 2'd2);

        // ---- Non-owner done ignored; simultaneous done+req drop = one release ----
        bus.req = 4'b0010;
        tick();
        check_state("ign.grant1", 4'b0010, 2'd1, 1'b1, 2'd2);
        bus.done = 4'b0100;
        tick();
        check_state("ign.held", 4'b0010, 2'd1, 1'b1, 2'd2);
        bus.done = 4'b0010;
        bus.req  = 4'b0000;
        tick();
        bus.done = 4'b0000;
        check_state("ign.release", 4'b0000, 2'd0, 1'b0, 2'd2);
        check("ign.timeout", 32'(bus.timeout), 32'd0);
        bus.done = 4'b1111;
        tick();
        bus.done = 4'b0000;
        check_state("idle_done_ignored", 4'b0000, 2'd0, 1'b0, 2'd2);

        // ---- Owner holds req with no done ----
        bus.req = 4'b0001;
        tick();
        check_state("hold.grant", 4'b0001, 2'd0, 1'b1, 2'd2);
`ifdef RR_HOLD_LIMIT_EN
        for (int k = 2; k <= 4; k++) begin
            tick();
            check($sformatf("hold.cycle%0d", k), 32'(bus.grant), 32'b0001);
            check($sformatf("hold.cycle%0d.timeout", k), 32'(bus.timeout), 32'd0);
        end
        tick();
        bus.req = 4'b0000;
        check_state("hold.forced", 4'b0000, 2'd0, 1'b0, 2'd1);
        check("hold.timeout_pulse", 32'(bus.timeout), 32'd1);
        tick();
        check("hold.timeout_clear", 32'(bus.timeout), 32'd0);
        check("hold.after", 32'(bus.grant), 32'd0);
`else
        for (int k = 0; k < 120; k++) begin
            tick();
            if (k % 30 == 29) begin
                check($sformatf("hold.cycle%0d", k), 32'(bus.grant), 32'b0001);
                check($sformatf("hold.cycle%0d.timeout", k), 32'(bus.timeout), 32'd0);
            end
        end
        bus.req = 4'b0000;
        tick();
        check_state("hold.release", 4'b0000, 2'd0, 1'b0, 2'd1);
        check("hold.timeout", 32'(bus.timeout), 32'd0);
`endif

        // ---- Asynchronous reset between edges, then fresh grant ----
        bus.req = 4'b0100;
        tick();
        check_state("arst.grant", 4'b0100, 2'd2, 1'b1, 2'd1);
        #3 rst_n = 1'b0;
        #1;
        check_state("arst.cleared", 4'b0000, 2'd0, 1'b0, 2'd0);
        bus.req = 4'b1000;
        #1 rst_n = 1'b1;
        tick();
        check_state("arst.regrant", 4'b1000, 2'd3, 1'b1, 2'd0);
        bus.done = 4'b1000;
        bus.req  = 4'b0000;
        tick();
        bus.done = 4'b0000;
        check_state("arst.wrap", 4'b0000, 2'd0, 1'b0, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #50000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_rr_grant_scheduler
